// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: shared VRAM geometry and arbiter state encoding
package vram_arbiter_pkg;
  localparam int VRAM_ADDR_W = 10;
  localparam int VRAM_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, VID_A, VID_D, CPU_WR, CPU_A, CPU_D} vram_arb_state_t;
endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM shared by video fetch (priority) and 8080 CPU
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = VRAM_ADDR_W,
  parameter int DATA_W      = VRAM_DATA_W,
  parameter bit VBLANK_ONLY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  vram_arb_state_t   r_state;
  logic              r_vid_pend;
  logic [ADDR_W-1:0] r_vid_addr;
  logic              r_cpu_done;
  logic [DATA_W-1:0] r_vid_data;
  logic              r_vid_valid;
  logic              r_vid_overrun;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              w_new_cpu;
  logic              w_cpu_ok;
  logic              w_cpu_addr;
  assign w_new_cpu  = cpu_req & ~r_cpu_done;
  assign w_cpu_ok   = w_new_cpu & (vblank | !VBLANK_ONLY);
  assign w_cpu_addr = (r_state == CPU_WR) || (r_state == CPU_A);
  assign ram_addr   = (r_state == VID_A) ? r_vid_addr : w_cpu_addr ? cpu_addr : '0;
  // Gate the strobe with reset so a reset landing in CPU_WR never writes
  assign ram_we     = (r_state == CPU_WR) & ~reset;
  assign ram_wdata  = (r_state == CPU_WR) ? cpu_wdata : '0;
  assign cpu_ready  = ~w_new_cpu | reset;
  assign vid_data   = r_vid_data;
  assign vid_valid  = r_vid_valid;
  assign vid_overrun = r_vid_overrun;
  assign cpu_rdata  = r_cpu_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_vid_pend    <= 1'b0;
      r_vid_addr    <= '0;
      r_cpu_done    <= 1'b0;
      r_vid_data    <= '0;
      r_vid_valid   <= 1'b0;
      r_vid_overrun <= 1'b0;
      r_cpu_rdata   <= '0;
    end else begin
      if (vid_req) r_vid_addr <= vid_addr;
      r_vid_pend    <= vid_req | (r_vid_pend & (r_state != VID_A));
      r_vid_overrun <= r_vid_overrun | (vid_req & r_vid_pend);
      // Held requests stay marked done until the CPU drops cpu_req
      r_cpu_done    <= cpu_req & (r_cpu_done | (r_state == CPU_WR) | (r_state == CPU_D));
      r_vid_valid   <= r_state == VID_D;
      if (r_state == VID_D) r_vid_data <= ram_rdata;
      if (r_state == CPU_D) r_cpu_rdata <= ram_rdata;
      case (r_state)
        IDLE:    r_state <= (r_vid_pend | vid_req) ? VID_A : w_cpu_ok ? (cpu_wr ? CPU_WR : CPU_A) : IDLE;
        VID_A:   r_state <= VID_D;
        CPU_A:   r_state <= CPU_D;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter against a behavioural VRAM
module tb_vram_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vblank = 1'b0;
  logic       vid_req = 1'b0;
  logic [9:0] vid_addr = '0;
  logic [7:0] vid_data;
  logic       vid_valid;
  logic       vid_overrun;
  logic       cpu_req = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_ready;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic [7:0] mem [0:1023];
  int n_chk = 0;
  int n_err = 0;
  int cnt;

  vram_arbiter #(.ADDR_W(10), .DATA_W(8), .VBLANK_ONLY(1'b1)) dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_overrun(vid_overrun),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[10'h155] = 8'h2A;
    cyc();
    cyc();
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    chk("rst_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_vvalid", 32'(vid_valid), 32'h0);
    chk("rst_vdata", 32'(vid_data), 32'h0);
    chk("rst_ovr", 32'(vid_overrun), 32'h0);
    chk("rst_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_ready", 32'(cpu_ready), 32'h1);
    reset = 1'b0;
    cyc();

    vid_req = 1'b1; vid_addr = 10'h155;
    #1 chk("t1_ready0", 32'(cpu_ready), 32'h1);
    cyc();
    vid_req = 1'b0; vid_addr = '0;
    chk("t1_addr", 32'(ram_addr), 32'h155);
    chk("t1_ready1", 32'(cpu_ready), 32'h1);
    chk("t1_valid1", 32'(vid_valid), 32'h0);
    cyc();
    chk("t1_valid2", 32'(vid_valid), 32'h0);
    cyc();
    chk("t1_valid3", 32'(vid_valid), 32'h1);
    chk("t1_data", 32'(vid_data), 32'h2A);
    chk("t1_ready3", 32'(cpu_ready), 32'h1);
    cyc();
    chk("t1_valid4", 32'(vid_valid), 32'h0);

    vblank = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'h7E;
    #1 chk("t2_ready0", 32'(cpu_ready), 32'h0);
    chk("t2_we0", 32'(ram_we), 32'h0);
    cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      cnt += int'(ram_we);
      if (i == 1) begin
        chk("t2_we1", 32'(ram_we), 32'h1);
        chk("t2_addr1", 32'(ram_addr), 32'h3FF);
        chk("t2_wdata1", 32'(ram_wdata), 32'h7E);
        chk("t2_ready1", 32'(cpu_ready), 32'h0);
      end else chk($sformatf("t2_ready%0d", i), 32'(cpu_ready), 32'h1);
    end
    chk("t2_wecount", 32'(cnt), 32'h1);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    cyc();
    chk("t2_mem", 32'(mem[10'h3FF]), 32'h7E);

    vblank = 1'b0; cpu_req = 1'b1; cpu_addr = 10'h010;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      cnt += int'(cpu_ready);
    end
    chk("t3_stall", 32'(cnt), 32'h0);
    vblank = 1'b1;
    #1 chk("t3_ready0", 32'(cpu_ready), 32'h0);
    cyc();
    cyc();
    chk("t3_ready2", 32'(cpu_ready), 32'h0);
    cyc();
    chk("t3_ready3", 32'(cpu_ready), 32'h1);
    chk("t3_rdata", 32'(cpu_rdata), 32'hB5);
    cpu_req = 1'b0;
    cyc();

    vid_req = 1'b1; vid_addr = 10'h155;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h020; cpu_wdata = 8'h99;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      vid_req = 1'b0;
      chk($sformatf("t4_valid%0d", i), 32'(vid_valid), 32'(i == 3));
      chk($sformatf("t4_we%0d", i), 32'(ram_we), 32'(i == 4));
    end
    chk("t4_vdata", 32'(vid_data), 32'h2A);
    cpu_req = 1'b0; cpu_wr = 1'b0;
    cyc();
    chk("t4_mem", 32'(mem[10'h020]), 32'h99);

    cpu_req = 1'b1; cpu_addr = 10'h030;
    cyc();
    vid_req = 1'b1; vid_addr = 10'h040;
    cyc();
    vid_addr = 10'h050;
    cyc();
    vid_req = 1'b0; vid_addr = '0;
    chk("t5_ovr", 32'(vid_overrun), 32'h1);
    chk("t5_ready", 32'(cpu_ready), 32'h1);
    chk("t5_rdata", 32'(cpu_rdata), 32'h95);
    cpu_req = 1'b0;
    cyc();
    chk("t5_addr", 32'(ram_addr), 32'h050);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (vid_valid) begin
        cnt++;
        chk("t5_vdata", 32'(vid_data), 32'hF5);
      end
    end
    chk("t5_vcount", 32'(cnt), 32'h1);
    chk("t5_ovr_sticky", 32'(vid_overrun), 32'h1);

    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'h060; cpu_wdata = 8'h11;
    cyc();
    reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0;
    #1 chk("t6_we_in", 32'(ram_we), 32'h0);
    cyc();
    chk("t6_we", 32'(ram_we), 32'h0);
    chk("t6_addr", 32'(ram_addr), 32'h0);
    chk("t6_wdata", 32'(ram_wdata), 32'h0);
    chk("t6_ready", 32'(cpu_ready), 32'h1);
    chk("t6_ovr", 32'(vid_overrun), 32'h0);
    chk("t6_vvalid", 32'(vid_valid), 32'h0);
    chk("t6_vdata", 32'(vid_data), 32'h0);
    chk("t6_rdata", 32'(cpu_rdata), 32'h0);
    reset = 1'b0;
    cyc();
    cyc();
    chk("t6_mem", 32'(mem[10'h060]), 32'hC5);
    chk("t6_idle_we", 32'(ram_we), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
